// File: rtl/axi2s_mreg.sv
// ============================================================================
// axi2s_mreg : multi-channel AXI-to-stream DMA register bank with
//              double-buffered TDD frame timing and frame-adjust handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module axi2s_mreg #(
  parameter logic [17:0] BASE = 18'h00000,
  parameter int          NCH  = 2,
  parameter int          AW   = 32,
  parameter int          TW   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wen,
  input  logic [17:0]       addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              rvalid,
  output logic [NCH-1:0]    ien,
  output logic [NCH-1:0]    oen,
  output logic [NCH*AW-1:0] ibase,
  output logic [NCH*AW-1:0] obase,
  output logic [NCH*18-1:0] isize,
  output logic [NCH*18-1:0] osize,
  input  logic [NCH*18-1:0] iacnt,
  input  logic [NCH*18-1:0] oacnt,
  input  logic [NCH-1:0]    err_in,
  output logic              tddmode,
  output logic [TW-1:0]     frame_len,
  output logic [TW-1:0]     tstart,
  output logic [TW-1:0]     tend,
  output logic [TW-1:0]     rstart,
  output logic [TW-1:0]     rend,
  input  logic              frame_sync,
  output logic              adj_valid,
  output logic [TW-1:0]     frame_adj,
  input  logic              adj_ready
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} adj_state_t;

  localparam int            NTIM     = 5;
  localparam int            T_LEN    = 0;
  localparam int            T_TE     = 2;
  localparam int            T_RE     = 4;
  localparam logic [AW-1:0] BASE_RST = AW'(32'hfffc0000);
  localparam logic [17:0]   SIZE_RST = 18'h400;

  // Timing slots in order: FRAME_LEN, TSTART, TEND, RSTART, REND
  function automatic logic [TW-1:0] tim_rst(input int i);
    if (i == T_LEN)             return TW'(1920);
    if (i == T_TE || i == T_RE) return TW'(1919);
    return '0;
  endfunction

  function automatic logic [7:0] tim_off(input int i);
    return (i == 0) ? 8'h20 : 8'(8'h2C + 4 * i);
  endfunction

  logic [31:0]   dout_q, dout_d, rdata;
  logic          rvalid_q, rvalid_d;
  logic [NCH-1:0] ien_q, ien_d, oen_q, oen_d, err_q, err_d, err_clr;
  logic [AW-1:0] ibase_q [NCH], ibase_d [NCH], obase_q [NCH], obase_d [NCH];
  logic [17:0]   isize_q [NCH], isize_d [NCH], osize_q [NCH], osize_d [NCH];
  logic [TW-1:0] tim_q [NTIM], tim_d [NTIM], tim_sh_q [NTIM], tim_sh_d [NTIM];
  logic          tdd_q, tdd_d, sh_tdd_q, sh_tdd_d;
  logic          commit_q, commit_d, overrun_q, overrun_d, overrun_clr, overrun_set;
  adj_state_t    state_q, state_d;
  logic [TW-1:0] frame_adj_q, frame_adj_d;

  logic       acc, wr, wr_adj, ch_rgn;
  logic [7:0] off;
  logic [2:0] ch_idx;

  assign acc    = en && (addr[17:8] == BASE[17:8]);
  assign wr     = acc && wen;
  assign off    = addr[7:0];
  assign wr_adj = wr && (off == 8'h24);
  assign ch_rgn = (off[7:6] != 2'b00);
  assign ch_idx = off[7:5] - 3'd2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q      <= '0;
      rvalid_q    <= 1'b0;
      ien_q       <= '0;
      oen_q       <= '0;
      err_q       <= '0;
      tdd_q       <= 1'b0;
      sh_tdd_q    <= 1'b0;
      commit_q    <= 1'b0;
      overrun_q   <= 1'b0;
      state_q     <= S_IDLE;
      frame_adj_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        ibase_q[c] <= BASE_RST;
        obase_q[c] <= BASE_RST;
        isize_q[c] <= SIZE_RST;
        osize_q[c] <= SIZE_RST;
      end
      for (int i = 0; i < NTIM; i++) begin
        tim_q[i]    <= tim_rst(i);
        tim_sh_q[i] <= tim_rst(i);
      end
    end else begin
      dout_q      <= dout_d;
      rvalid_q    <= rvalid_d;
      ien_q       <= ien_d;
      oen_q       <= oen_d;
      err_q       <= err_d;
      tdd_q       <= tdd_d;
      sh_tdd_q    <= sh_tdd_d;
      commit_q    <= commit_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
      frame_adj_q <= frame_adj_d;
      ibase_q     <= ibase_d;
      obase_q     <= obase_d;
      isize_q     <= isize_d;
      osize_q     <= osize_d;
      tim_q       <= tim_d;
      tim_sh_q    <= tim_sh_d;
    end
  end

  // Read mux always reflects pre-write register contents
  always_comb begin
    rdata = '0;
    case (off)
      8'h00:   rdata[0] = sh_tdd_q;
      8'h04: begin
        rdata[0]       = (state_q == S_REQ);
        rdata[1]       = commit_q;
        rdata[2]       = overrun_q;
        rdata[8 +: NCH] = err_q;
      end
      8'h24:   rdata = 32'(frame_adj_q);
      default: ;
    endcase
    for (int i = 0; i < NTIM; i++)
      if (off == tim_off(i)) rdata = 32'(tim_sh_q[i]);
    for (int c = 0; c < NCH; c++) begin
      if (ch_rgn && ch_idx == 3'(c)) begin
        case (off[4:0])
          5'h00:   rdata = {30'd0, oen_q[c], ien_q[c]};
          5'h04:   rdata = 32'(ibase_q[c]);
          5'h08:   rdata = {8'd0, isize_q[c], 6'd0};
          5'h0C:   rdata = 32'(obase_q[c]);
          5'h10:   rdata = {8'd0, osize_q[c], 6'd0};
          5'h14:   rdata = {8'd0, iacnt[c*18 +: 18], 6'd0};
          5'h18:   rdata = {8'd0, oacnt[c*18 +: 18], 6'd0};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dout_d      = acc ? rdata : dout_q;
    rvalid_d    = acc;
    ien_d       = ien_q;
    oen_d       = oen_q;
    ibase_d     = ibase_q;
    obase_d     = obase_q;
    isize_d     = isize_q;
    osize_d     = osize_q;
    tim_d       = tim_q;
    tim_sh_d    = tim_sh_q;
    tdd_d       = tdd_q;
    sh_tdd_d    = sh_tdd_q;
    commit_d    = commit_q;
    state_d     = state_q;
    frame_adj_d = frame_adj_q;
    overrun_set = 1'b0;
    overrun_clr = 1'b0;
    err_clr     = '0;

    // Commit uses the shadow values held before this edge
    if (frame_sync && commit_q) begin
      tim_d    = tim_sh_q;
      tdd_d    = sh_tdd_q;
      commit_d = 1'b0;
    end

    if (wr) begin
      case (off)
        8'h00:   sh_tdd_d = din[0];
        8'h04: begin
          overrun_clr = din[2];
          err_clr     = din[8 +: NCH];
        end
        8'h08:   if (din[0]) commit_d = 1'b1;
        default: ;
      endcase
      for (int i = 0; i < NTIM; i++)
        if (off == tim_off(i)) tim_sh_d[i] = TW'(din);
      for (int c = 0; c < NCH; c++) begin
        if (ch_rgn && ch_idx == 3'(c)) begin
          case (off[4:0])
            5'h00: begin
              ien_d[c] = din[0];
              oen_d[c] = din[1];
            end
            5'h04:   ibase_d[c] = AW'(din);
            5'h08:   isize_d[c] = din[23:6];
            5'h0C:   obase_d[c] = AW'(din);
            5'h10:   osize_d[c] = din[23:6];
            default: ;
          endcase
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (wr_adj) begin
          state_d     = S_REQ;
          frame_adj_d = TW'(din);
        end
      end
      S_REQ: begin
        if (wr_adj)    overrun_set = 1'b1;
        if (adj_ready) state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    overrun_d = (overrun_q & ~overrun_clr) | overrun_set;
    err_d     = (err_q & ~err_clr) | err_in;
  end

  assign dout      = dout_q;
  assign rvalid    = rvalid_q;
  assign ien       = ien_q;
  assign oen       = oen_q;
  assign tddmode   = tdd_q;
  assign frame_len = tim_q[0];
  assign tstart    = tim_q[1];
  assign tend      = tim_q[2];
  assign rstart    = tim_q[3];
  assign rend      = tim_q[4];
  assign adj_valid = (state_q == S_REQ);
  assign frame_adj = frame_adj_q;

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign ibase[c*AW +: AW] = ibase_q[c];
      assign obase[c*AW +: AW] = obase_q[c];
      assign isize[c*18 +: 18] = isize_q[c];
      assign osize[c*18 +: 18] = osize_q[c];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_axi2s_mreg.sv
// ============================================================================
// tb_axi2s_mreg : self-checking bench for axi2s_mreg (NCH=2, AW=32, TW=24)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi2s_mreg;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int TW  = 24;

  logic              clk = 1'b0;
  logic              rst, en, wen, frame_sync, adj_ready, rvalid, tddmode, adj_valid;
  logic [17:0]       addr;
  logic [31:0]       din, dout;
  logic [NCH-1:0]    ien, oen, err_in;
  logic [NCH*AW-1:0] ibase, obase;
  logic [NCH*18-1:0] isize, osize, iacnt, oacnt;
  logic [TW-1:0]     frame_len, tstart, tend, rstart, rend, frame_adj;

  axi2s_mreg #(.BASE(18'h00000), .NCH(NCH), .AW(AW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .din(din),
    .dout(dout), .rvalid(rvalid), .ien(ien), .oen(oen),
    .ibase(ibase), .obase(obase), .isize(isize), .osize(osize),
    .iacnt(iacnt), .oacnt(oacnt), .err_in(err_in), .tddmode(tddmode),
    .frame_len(frame_len), .tstart(tstart), .tend(tend), .rstart(rstart), .rend(rend),
    .frame_sync(frame_sync), .adj_valid(adj_valid), .frame_adj(frame_adj),
    .adj_ready(adj_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [7:0]  off;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  off;
    logic [31:0] exp;
  } sb_t;

  int   ntests = 0;
  int   nfail  = 0;
  sb_t  sbq[$];
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every access returns one read beat; expected data is queued when driven
  always @(negedge clk) begin
    if (rst && rvalid) begin
      if (sbq.size() == 0) begin
        chk("rvalid_spurious", 64'(rvalid), 64'd0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk($sformatf("rd_%02h", e.off), 64'(dout), 64'(e.exp));
      end
    end
  end

  task automatic clr_pulses();
    en = 1'b0; wen = 1'b0; frame_sync = 1'b0; adj_ready = 1'b0; err_in = '0;
  endtask

  task automatic acc(input logic w, input logic [7:0] off, input logic [31:0] d,
                     input logic [31:0] exp);
    sb_t e;
    en = 1'b1; wen = w; addr = {10'd0, off}; din = d;
    e.off = off; e.exp = exp;
    sbq.push_back(e);
    @(posedge clk); #1;
    clr_pulses();
  endtask

  task automatic idle();
    @(posedge clk); #1;
    clr_pulses();
  endtask

  initial begin
    rst = 1'b0; addr = '0; din = '0;
    iacnt = {18'h3FFFF, 18'h00123};
    oacnt = {18'h00002, 18'h00001};
    clr_pulses();
    repeat (3) @(posedge clk);
    #1;

    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_ien_oen", 64'({ien, oen}), 64'd0);
    chk("rst_tdd", 64'(tddmode), 64'd0);
    chk("rst_ibase", ibase, {2{32'hfffc0000}});
    chk("rst_osize", 64'(osize), 64'({2{18'h400}}));
    chk("rst_timing", {frame_len, tstart, tend[15:0]}, {24'd1920, 24'd0, 16'd1919});
    chk("rst_rtiming", 64'({rstart, rend}), 64'({24'd0, 24'd1919}));
    chk("rst_adj", 64'({adj_valid, frame_adj}), 64'd0);
    rst = 1'b1;

    vecs.push_back('{1'b0, 8'h20, 32'h0, 32'd1920});
    vecs.push_back('{1'b0, 8'h3C, 32'h0, 32'd1919});
    vecs.push_back('{1'b0, 8'h44, 32'h0, 32'hfffc0000});
    vecs.push_back('{1'b0, 8'h48, 32'h0, 32'h00010000});
    vecs.push_back('{1'b0, 8'h30, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 8'h04, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 8'h50, 32'h0, 32'h00010000});
    vecs.push_back('{1'b1, 8'h64, 32'h12345678, 32'hfffc0000});
    vecs.push_back('{1'b1, 8'h60, 32'h3, 32'h0});
    vecs.push_back('{1'b0, 8'h64, 32'h0, 32'h12345678});
    vecs.push_back('{1'b0, 8'h60, 32'h0, 32'h3});
    vecs.push_back('{1'b0, 8'h44, 32'h0, 32'hfffc0000});
    vecs.push_back('{1'b0, 8'h40, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 8'hA0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 8'h10, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 8'h54, 32'h0, 32'h000048C0});
    vecs.push_back('{1'b0, 8'h74, 32'h0, 32'h00FFFFC0});
    vecs.push_back('{1'b0, 8'h58, 32'h0, 32'h00000040});
    vecs.push_back('{1'b0, 8'h78, 32'h0, 32'h00000080});
    vecs.push_back('{1'b1, 8'h6C, 32'hA5A50000, 32'hfffc0000});
    vecs.push_back('{1'b1, 8'h68, 32'h00FFFFFF, 32'h00010000});
    vecs.push_back('{1'b0, 8'h68, 32'h0, 32'h00FFFFC0});
    vecs.push_back('{1'b1, 8'h34, 32'd959, 32'd1919});
    vecs.push_back('{1'b0, 8'h34, 32'h0, 32'd959});
    for (int i = 0; i < vecs.size(); i++)
      acc(vecs[i].w, vecs[i].off, vecs[i].d, vecs[i].exp);
    idle();
    chk("rvalid_idle", 64'(rvalid), 64'd0);

    chk("ch1_ibase", 64'(ibase[63:32]), 64'h12345678);
    chk("ch0_ibase", 64'(ibase[31:0]), 64'hfffc0000);
    chk("ch1_obase", 64'(obase[63:32]), 64'hA5A50000);
    chk("ch1_isize", 64'(isize[35:18]), 64'h3FFFF);
    chk("ien_oen", 64'({ien, oen}), 64'b1010);
    chk("tend_shadowed", 64'(tend), 64'd1919);

    // COMMIT coinciding with frame_sync waits for the next sync
    frame_sync = 1'b1;
    acc(1'b1, 8'h08, 32'h1, 32'h0);
    chk("commit_same_sync", 64'(tend), 64'd1919);
    acc(1'b0, 8'h04, 32'h0, 32'h2);
    frame_sync = 1'b1;
    idle();
    chk("commit_next_sync", 64'(tend), 64'd959);
    chk("commit_len_kept", 64'(frame_len), 64'd1920);
    acc(1'b0, 8'h04, 32'h0, 32'h0);

    // Shadow write during a committing sync: old shadow is committed
    acc(1'b1, 8'h00, 32'h1, 32'h0);
    acc(1'b1, 8'h08, 32'h1, 32'h0);
    frame_sync = 1'b1;
    acc(1'b1, 8'h34, 32'd100, 32'd959);
    chk("commit_old_shadow", 64'(tend), 64'd959);
    chk("commit_tdd", 64'(tddmode), 64'd1);
    acc(1'b1, 8'h08, 32'h1, 32'h0);
    frame_sync = 1'b1;
    idle();
    chk("commit_new_shadow", 64'(tend), 64'd100);

    // Frame adjust handshake and overrun
    acc(1'b1, 8'h24, 32'd5, 32'd0);
    chk("adj_req", 64'({adj_valid, frame_adj}), 64'({1'b1, 24'd5}));
    acc(1'b1, 8'h24, 32'd9, 32'd5);
    chk("adj_hold", 64'(frame_adj), 64'd5);
    acc(1'b0, 8'h04, 32'h0, 32'h5);
    adj_ready = 1'b1;
    idle();
    chk("adj_done", 64'(adj_valid), 64'd0);
    acc(1'b1, 8'h04, 32'h4, 32'h4);
    acc(1'b0, 8'h04, 32'h0, 32'h0);
    acc(1'b1, 8'h24, 32'd7, 32'd5);
    adj_ready = 1'b1;
    acc(1'b1, 8'h24, 32'd8, 32'd7);
    chk("adj_race", 64'({adj_valid, frame_adj}), 64'({1'b0, 24'd7}));
    acc(1'b1, 8'h04, 32'h4, 32'h4);

    // Sticky errors: set beats a coincident W1C
    err_in = 2'b01;
    acc(1'b1, 8'h04, 32'h100, 32'h0);
    acc(1'b0, 8'h04, 32'h0, 32'h100);
    acc(1'b1, 8'h04, 32'h100, 32'h100);
    err_in = 2'b10;
    acc(1'b0, 8'h04, 32'h0, 32'h0);
    acc(1'b0, 8'h04, 32'h0, 32'h200);

    // Asynchronous reset with a pending commit and an open adjust request
    acc(1'b1, 8'h08, 32'h1, 32'h0);
    acc(1'b1, 8'h24, 32'd3, 32'd7);
    idle();
    chk("pre_rst_adj", 64'(adj_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_adj", 64'({adj_valid, frame_adj}), 64'd0);
    chk("arst_out", 64'({dout, rvalid, ien, oen, tddmode}), 64'd0);
    chk("arst_tend", 64'(tend), 64'd1919);
    chk("arst_ibase", ibase, {2{32'hfffc0000}});
    @(posedge clk); #1;
    rst = 1'b1;
    acc(1'b0, 8'h04, 32'h0, 32'h0);
    acc(1'b0, 8'h64, 32'h0, 32'hfffc0000);

    repeat (3) idle();
    chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
